// File: rtl/defs.sv
// Shared instruction and memory-access type definitions.
// Imported by the pipeline stages and their benches.
package defs;

  typedef enum logic [2:0] {
    NOP,
    MATH,
    LOAD,
    STORE,
    ENV
  } instr_type_t;

  typedef enum logic [2:0] {
    BYTE,
    BYTE_UNSIGNED,
    HALF,
    HALF_UNSIGNED,
    WORD
  } mem_type_t;

endpackage

// File: rtl/memory_access_if.sv
// Request/acknowledge data-memory port.
// master = the pipeline side, slave = the memory side.
interface memory_access_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/memory_access.sv
// Memory-access stage: LOAD/STORE over a req/ack port, others pass in 1 cycle.
// Optional MISALIGN_TRAP_EN traps misaligned HALF/WORD accesses at accept.
module memory_access
  import defs::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  instr_type_t in_instr_type,
  input  mem_type_t   in_mem_type,
  input  logic [4:0]  in_dest,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_res,
  input  logic [31:0] in_store_data,
  output logic        stall,
  memory_access_if.master mem,
  output instr_type_t out_instr_type,
  output mem_type_t   out_mem_type,
  output logic [4:0]  out_dest,
  output logic [31:0] out_imm,
  output logic [31:0] out_res,
  output logic [31:0] out_mem_rd,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_fault,
`endif
  output logic        bus_error
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  instr_type_t pend_q, pend_d;
  instr_type_t otype_q, otype_d;
  mem_type_t   omt_q, omt_d;
  logic [4:0]  odest_q, odest_d;
  logic [31:0] oimm_q, oimm_d;
  logic [31:0] ores_q, ores_d;
  logic [31:0] ord_q, ord_d;
  logic        berr_q, berr_d;
  logic        mis_q, mis_d;

  logic is_mem, is_byte, is_half, is_word, mis_a;

  always_comb begin
    is_mem  = (in_instr_type == LOAD) ||
              (in_instr_type == STORE);
    is_byte = (in_mem_type == BYTE) ||
              (in_mem_type == BYTE_UNSIGNED);
    is_half = (in_mem_type == HALF) ||
              (in_mem_type == HALF_UNSIGNED);
    is_word = !is_byte && !is_half;
`ifdef MISALIGN_TRAP_EN
    mis_a = (is_half && in_res[0]) ||
            (is_word && (in_res[1:0] != 2'b00));
`else
    mis_a = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    off_d   = off_q;
    pend_d  = pend_q;
    otype_d = NOP;
    omt_d   = omt_q;
    odest_d = odest_q;
    oimm_d  = oimm_q;
    ores_d  = ores_q;
    ord_d   = ord_q;
    berr_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          omt_d   = in_mem_type;
          odest_d = in_dest;
          oimm_d  = in_imm;
          ores_d  = in_res;
          if (!is_mem) begin
            otype_d = in_instr_type;
            ord_d   = '0;
          end else if (mis_a) begin
            mis_d = 1'b1;
          end else begin
            pend_d  = in_instr_type;
            req_d   = 1'b1;
            we_d    = (in_instr_type == STORE);
            addr_d  = {in_res[31:2], 2'b00};
            off_d   = in_res[1:0];
            cnt_d   = '0;
            state_d = WAIT;
            be_d    = 4'b1111;
            wdata_d = '0;
            if (in_instr_type == STORE) begin
              unique case (1'b1)
                is_byte: begin
                  wdata_d = {4{in_store_data[7:0]}};
                  be_d    = 4'b0001 << in_res[1:0];
                end
                is_half: begin
                  wdata_d = {2{in_store_data[15:0]}};
                  be_d    = 4'b0011 << {in_res[1], 1'b0};
                end
                default: begin
                  wdata_d = in_store_data;
                  be_d    = 4'b1111;
                end
              endcase
            end
          end
        end
      end
      WAIT: begin
        // ack wins over a timeout landing in the same cycle
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
          otype_d = pend_q;
          ord_d   = (pend_q == LOAD) ?
                    (mem.mem_rdata >> {off_q, 3'b000}) :
                    '0;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      pend_q  <= NOP;
      otype_q <= NOP;
      omt_q   <= BYTE;
      odest_q <= '0;
      oimm_q  <= '0;
      ores_q  <= '0;
      ord_q   <= '0;
      berr_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      pend_q  <= pend_d;
      otype_q <= otype_d;
      omt_q   <= omt_d;
      odest_q <= odest_d;
      oimm_q  <= oimm_d;
      ores_q  <= ores_d;
      ord_q   <= ord_d;
      berr_q  <= berr_d;
      mis_q   <= mis_d;
    end
  end

  assign stall          = (state_q == WAIT);
  assign mem.mem_req    = req_q;
  assign mem.mem_we     = we_q;
  assign mem.mem_addr   = addr_q;
  assign mem.mem_be     = be_q;
  assign mem.mem_wdata  = wdata_q;
  assign out_instr_type = otype_q;
  assign out_mem_type   = omt_q;
  assign out_dest       = odest_q;
  assign out_imm        = oimm_q;
  assign out_res        = ores_q;
  assign out_mem_rd     = ord_q;
  assign bus_error      = berr_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_fault = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Pipeline stage between execute and register_writeback.
- Performs LOAD/STORE transactions on a request/acknowledge data-memory port, and passes all other instructions through with 1-cycle latency.
- Drives writeback-stage inputs from a registered output bank.
- Stalls upstream while a memory transaction is outstanding.

Parameters:
- ACK_TIMEOUT, 255: max cycles in WAIT before the transaction is abandoned as a bus error; counter width is $clog2(ACK_TIMEOUT+1).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream presents an instruction this cycle
- in_instr_type  input  instr_type_t  instruction class (defs.sv)
- in_mem_type  input  mem_type_t  access width/signedness
- in_dest  input  5  destination register
- in_imm  input  32  immediate, passed through
- in_res  input  32  ALU result; effective address for LOAD/STORE
- in_store_data  input  32  rs2 value for STORE
- stall  output  1  upstream must hold its instruction stable
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address, bits [1:0] = 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_ack  input  1  transaction complete; mem_rdata valid this cycle
- mem_rdata  input  32  read word
- out_instr_type  output  instr_type_t  to writeback; NOP when empty
- out_mem_type, out_dest, out_imm, out_res  output  as inputs  registered copies
- out_mem_rd  output  32  read word shifted right by 8*addr[1:0]
- bus_error  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (async, immediate):
  - state = IDLE; mem_req, mem_we, stall, bus_error = 0.
  - mem_be = 0; mem_addr, mem_wdata, out_* = 0.
  - out_instr_type = NOP.
  - A transaction in flight is dropped, with no retry after reset.
- States: IDLE, WAIT.
- IDLE, accepting input (accept = in_valid):
  - Non-memory type: out_* <= in_*; out_mem_rd <= 0; stays IDLE.
  - LOAD or STORE:
    - Latch in_dest, in_imm, in_res, in_mem_type and the type.
    - Drive mem_addr = {in_res[31:2],2'b00}; mem_we = STORE.
    - Set mem_req <= 1; out_instr_type <= NOP; go to WAIT.
  - in_valid = 0: out_instr_type <= NOP.
- WAIT:
  - stall = 1 (registered; asserted in cycles where state == WAIT); out_instr_type = NOP.
  - Timeout counter increments every cycle without mem_ack.
  - On mem_ack:
    - mem_req <= 0; go to IDLE.
    - Latched instruction is released to out_*; LOAD sets out_mem_rd <= mem_rdata >> (8*addr[1:0]); STORE sets out_mem_rd <= 0.
  - Counter reaches ACK_TIMEOUT without ack: mem_req <= 0; bus_error pulses 1 cycle; out_instr_type <= NOP (no writeback); go to IDLE.
  - mem_ack in the same cycle as the timeout is treated as ack, with no error.
  - mem_ack while IDLE is ignored.
- Latency:
  - Non-memory: 1 cycle.
  - Memory, accepted at cycle N:
    - mem_req is high from N+1.
    - Ack at cycle N+k gives out_* valid at N+k+1.
    - stall is high for cycles N+1..N+k.
- Store lanes:
  - BYTE: wdata = {4{d[7:0]}}, be = 4'b0001 << a[1:0].
  - HALF: wdata = {2{d[15:0]}}, be = 4'b0011 << {a[1],1'b0}.
  - WORD: wdata = d, be = 4'b1111.
- Loads: be = 4'b1111 regardless of width; sign/zero extension is done downstream.
- ENV passes through like MATH.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Misaligned accesses are detected at accept, with no memory request and no WAIT: HALF/HALF_UNSIGNED with a[0] = 1, or WORD with a[1:0] != 0.
  - Next cycle: out_instr_type = NOP and misalign_fault (extra 1-bit output, reset 0) pulses 1 cycle.
- Undefined:
  - Port absent.
  - HALF ignores a[0]; WORD ignores a[1:0]; access proceeds normally.

Test Plan:
- MATH, in_res = 32'h1234, dest = 5 -> next cycle out_instr_type = MATH, out_res = 32'h1234, out_dest = 5; stall never high.
- LOAD BYTE, addr 32'h103, ack after 3 cycles with rdata 32'hAB00_0000 -> mem_addr = 32'h100, mem_be = 4'hF, stall high 3 cycles, out_mem_rd = 32'h0000_00AB one cycle after ack.
- STORE HALF, addr 32'h202, data 32'hDEAD_BEEF -> mem_we = 1, mem_be = 4'b1100, mem_wdata = 32'hBEEF_BEEF; after ack out_instr_type = STORE.
- ACK_TIMEOUT = 4, LOAD, no ack -> mem_req drops after 4 WAIT cycles, bus_error single pulse, out_instr_type = NOP, back to IDLE.
- rst_n low during WAIT -> mem_req and stall = 0 immediately; after release, a MATH passes through normally; late mem_ack ignored.
- MISALIGN_TRAP_EN, WORD LOAD addr 32'h101 -> mem_req stays 0, misalign_fault pulses, out_instr_type = NOP.
